scs8hd_lpflow_lsbuf_hl_rx: RTL and testbench

- Receive-end controller for a 4-phase REQ/ACK crossing whose REQ and DATA arrive through a high-to-low level-shifter buffer from a separately powered domain.
- Synchronizes REQ and the source-domain isolation flag into the local clock domain.
- Captures DATA while REQ is held, presents it to a local valid/ready consumer, and returns ACK.
- Sits directly after the level-shifter bank in the always-on destination domain.

---
 rtl/scs8hd_lpflow_xing_pkg.sv | 24 ++
 rtl/scs8hd_lpflow_sync_n.sv | 35 +++
 rtl/scs8hd_lpflow_lsbuf_hl_rx.sv | 181 ++++++++++++++++++
 tb/tb_scs8hd_lpflow_lsbuf_hl_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scs8hd_lpflow_xing_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_lpflow_xing_pkg
// Shared definitions for the receive-side REQ/ACK level-shifter crossing:
//   - xing_state_t : receive controller states
//   - ACK_CNT_W    : width of the ACK timeout counter
//   - REQ_SYNC_RST / ISO_SYNC_RST : reset values of the REQ and ISO
//     synchronizer chains. ISO resets to 1, so the controller assumes the
//     source is isolated until it has seen otherwise.
// -----------------------------------------------------------------------------
package scs8hd_lpflow_xing_pkg;

    typedef enum logic [1:0] {
        ISO_WAIT = 2'd0,
        IDLE     = 2'd1,
        HOLD     = 2'd2,
        ACK_WAIT = 2'd3
    } xing_state_t;

    localparam int ACK_CNT_W = 8;

    localparam logic REQ_SYNC_RST = 1'b0;
    localparam logic ISO_SYNC_RST = 1'b1;

endpackage : scs8hd_lpflow_xing_pkg

// File: rtl/scs8hd_lpflow_sync_n.sv
// -----------------------------------------------------------------------------
// scs8hd_lpflow_sync_n
// N-stage flop synchronizer for one asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset; every stage loads RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (last stage)
// Parameters:
//   STAGES  : chain depth, 2 or more
//   RST_VAL : value held by every stage while in reset
// -----------------------------------------------------------------------------
module scs8hd_lpflow_sync_n #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_reg <= {STAGES{RST_VAL}};
        end else begin
            stage_reg <= {stage_reg[STAGES-2:0], d};
        end
    end

    assign q = stage_reg[STAGES-1];

endmodule : scs8hd_lpflow_sync_n

// File: rtl/scs8hd_lpflow_lsbuf_hl_rx.sv
// -----------------------------------------------------------------------------
// scs8hd_lpflow_lsbuf_hl_rx
// Receive-end controller for a 4-phase REQ/ACK crossing arriving through a
// high-to-low level shifter. REQ and ISO are synchronized into CLK; DATA is
// captured once per handshake, offered to a local valid/ready consumer, and
// ACK is returned after the consumer takes it.
// Ports:
//   CLK      : destination-domain clock
//   RESET    : asynchronous active-high reset
//   REQ_IN   : request from source domain (asynchronous)
//   DATA_IN  : data from source domain, stable while REQ_IN is high
//   ISO_IN   : source isolation active (asynchronous)
//   ACK_OUT  : acknowledge to source domain
//   DATA_OUT : captured word
//   VALID    : DATA_OUT valid to local consumer
//   READY    : local consumer accepts on VALID & READY
//   ERR      : sticky protocol error (ACK timeout or isolation abort)
//   ERR_CLR  : synchronous clear of ERR (a coincident set wins)
// Parameters:
//   WIDTH       : data width
//   SYNC_STAGES : synchronizer depth, 2..4
//   ACK_TIMEOUT : max cycles ACK stays high waiting for REQ release, 1..255
// -----------------------------------------------------------------------------
module scs8hd_lpflow_lsbuf_hl_rx
    import scs8hd_lpflow_xing_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_IN,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             ISO_IN,
    output logic             ACK_OUT,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             VALID,
    input  logic             READY,
    output logic             ERR,
    input  logic             ERR_CLR
);

    localparam logic [ACK_CNT_W-1:0] TIMEOUT_LAST = ACK_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [ACK_CNT_W-1:0] CNT_ONE      = ACK_CNT_W'(1);

    logic req_s;
    logic iso_s;

    scs8hd_lpflow_sync_n #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (REQ_SYNC_RST)
    ) u_req_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (REQ_IN),
        .q   (req_s)
    );

    scs8hd_lpflow_sync_n #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (ISO_SYNC_RST)
    ) u_iso_sync (
        .clk (CLK),
        .rst (RESET),
        .d   (ISO_IN),
        .q   (iso_s)
    );

    xing_state_t            state_reg, state_next;
    logic                   ack_reg, ack_next;
    logic                   valid_reg, valid_next;
    logic [WIDTH-1:0]       data_reg, data_next;
    logic [ACK_CNT_W-1:0]   cnt_reg, cnt_next;
    logic                   err_reg, err_next;
    logic                   err_set;

    // ACK and VALID come straight from flops with async reset, so a reset
    // mid-handshake drops them without waiting for a clock edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ISO_WAIT;
            ack_reg   <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_next;
            valid_reg <= valid_next;
            data_reg  <= data_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ack_next   = ack_reg;
        valid_next = valid_reg;
        data_next  = data_reg;
        cnt_next   = cnt_reg;
        err_set    = 1'b0;

        unique case (state_reg)
            // Leave only once the source is powered and REQ is low, so a
            // stuck-high REQ after power-up or an error is never taken as new.
            ISO_WAIT: begin
                ack_next   = 1'b0;
                valid_next = 1'b0;
                if (!iso_s && !req_s) begin
                    state_next = IDLE;
                end
            end

            IDLE: begin
                ack_next   = 1'b0;
                valid_next = 1'b0;
                if (iso_s) begin
                    state_next = ISO_WAIT;
                end else if (req_s) begin
                    // DATA_IN has been stable since before REQ_IN rose, and
                    // req_s lags by SYNC_STAGES cycles, so it is settled here.
                    data_next  = DATA_IN;
                    valid_next = 1'b1;
                    state_next = HOLD;
                end
            end

            HOLD: begin
                if (iso_s) begin
                    valid_next = 1'b0;
                    ack_next   = 1'b0;
                    err_set    = 1'b1;
                    state_next = ISO_WAIT;
                end else if (READY) begin
                    valid_next = 1'b0;
                    ack_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ACK_WAIT;
                end
            end

            ACK_WAIT: begin
                if (iso_s) begin
                    valid_next = 1'b0;
                    ack_next   = 1'b0;
                    err_set    = 1'b1;
                    state_next = ISO_WAIT;
                end else if (!req_s) begin
                    ack_next   = 1'b0;
                    state_next = IDLE;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    // Counter entered at 0, so ACK has now been high for
                    // exactly ACK_TIMEOUT cycles.
                    ack_next   = 1'b0;
                    err_set    = 1'b1;
                    state_next = ISO_WAIT;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                ack_next   = 1'b0;
                valid_next = 1'b0;
                state_next = ISO_WAIT;
            end
        endcase

        // Set has priority over a coincident clear.
        err_next = err_set | (err_reg & ~ERR_CLR);
    end

    assign ACK_OUT  = ack_reg;
    assign VALID    = valid_reg;
    assign DATA_OUT = data_reg;
    assign ERR      = err_reg;

endmodule : scs8hd_lpflow_lsbuf_hl_rx

// File: tb/tb_scs8hd_lpflow_lsbuf_hl_rx.sv
// -----------------------------------------------------------------------------
// tb_scs8hd_lpflow_lsbuf_hl_rx
// Directed bench for the receive-side crossing controller. Inputs are driven
// and outputs sampled on the falling edge; expected data words are queued when
// a request is raised and popped when VALID appears.
// -----------------------------------------------------------------------------
module tb_scs8hd_lpflow_lsbuf_hl_rx;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int ACK_TIMEOUT = 15;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             REQ_IN;
    logic [WIDTH-1:0] DATA_IN;
    logic             ISO_IN;
    logic             ACK_OUT;
    logic [WIDTH-1:0] DATA_OUT;
    logic             VALID;
    logic             READY;
    logic             ERR;
    logic             ERR_CLR;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] sb_q[$];

    always #5 CLK = ~CLK;

    scs8hd_lpflow_lsbuf_hl_rx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .REQ_IN   (REQ_IN),
        .DATA_IN  (DATA_IN),
        .ISO_IN   (ISO_IN),
        .ACK_OUT  (ACK_OUT),
        .DATA_OUT (DATA_OUT),
        .VALID    (VALID),
        .READY    (READY),
        .ERR      (ERR),
        .ERR_CLR  (ERR_CLR)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise a request and remember what should come out.
    task automatic send(input logic [WIDTH-1:0] w);
        DATA_IN = w;
        REQ_IN  = 1'b1;
        sb_q.push_back(w);
        $display("[%0t] send 0x%02h", $time, w);
    endtask

    // Wait (bounded) for VALID, then pop and compare the word.
    task automatic wait_valid(input string tag, input int budget);
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < budget && VALID !== 1'b1; i++) tick(1);
        chk({tag, "_valid"}, {31'd0, VALID}, 32'd1);
        if (VALID === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                exp = sb_q.pop_front();
                chk({tag, "_data"}, {24'd0, DATA_OUT}, {24'd0, exp});
                $display("[%0t] recv 0x%02h expected 0x%02h", $time, DATA_OUT, exp);
            end
        end
    endtask

    // Wait (bounded) for ACK to drop after REQ release.
    task automatic wait_ack_low(input string tag, input int budget);
        for (int i = 0; i < budget && ACK_OUT !== 1'b0; i++) tick(1);
        chk({tag, "_ack_low"}, {31'd0, ACK_OUT}, 32'd0);
    endtask

    initial begin
        RESET   = 1'b1;
        REQ_IN  = 1'b0;
        DATA_IN = '0;
        ISO_IN  = 1'b0;
        READY   = 1'b0;
        ERR_CLR = 1'b0;
        tick(2);

        // Reset state
        chk("rst_ack",   {31'd0, ACK_OUT}, 32'd0);
        chk("rst_valid", {31'd0, VALID},   32'd0);
        chk("rst_data",  {24'd0, DATA_OUT}, 32'd0);
        chk("rst_err",   {31'd0, ERR},     32'd0);
        RESET = 1'b0;
        tick(4);

        // Basic transfer: exact latency REQ->VALID = SYNC_STAGES+1
        READY = 1'b1;
        send(8'hA5);
        tick(SYNC_STAGES);
        chk("basic_valid_early", {31'd0, VALID}, 32'd0);
        tick(1);
        wait_valid("basic", 1);
        tick(1);
        chk("basic_ack",      {31'd0, ACK_OUT}, 32'd1);
        chk("basic_valid_lo", {31'd0, VALID},   32'd0);
        REQ_IN = 1'b0;
        tick(SYNC_STAGES);
        chk("basic_ack_hold", {31'd0, ACK_OUT}, 32'd1);
        tick(1);
        chk("basic_ack_drop", {31'd0, ACK_OUT}, 32'd0);
        tick(2);

        // Consumer stall
        READY = 1'b0;
        send(8'h3C);
        wait_valid("stall", 8);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("stall_valid", {31'd0, VALID},    32'd1);
            chk("stall_data",  {24'd0, DATA_OUT}, 32'h3C);
            chk("stall_ack",   {31'd0, ACK_OUT},  32'd0);
        end
        READY = 1'b1;
        tick(1);
        chk("stall_rel_valid", {31'd0, VALID},   32'd0);
        chk("stall_rel_ack",   {31'd0, ACK_OUT}, 32'd1);
        REQ_IN = 1'b0;
        wait_ack_low("stall", 8);
        tick(2);

        // Timeout: ACK high for exactly ACK_TIMEOUT cycles
        send(8'h77);
        wait_valid("tmo", 8);
        tick(1);
        chk("tmo_ack_first", {31'd0, ACK_OUT}, 32'd1);
        for (int i = 1; i < ACK_TIMEOUT; i++) begin
            tick(1);
            chk("tmo_ack_hi", {31'd0, ACK_OUT}, 32'd1);
            chk("tmo_err_lo", {31'd0, ERR},     32'd0);
        end
        tick(1);
        chk("tmo_ack_drop", {31'd0, ACK_OUT}, 32'd0);
        chk("tmo_err_set",  {31'd0, ERR},     32'd1);
        // REQ still high: must stay parked in ISO_WAIT
        DATA_IN = 8'hEE;
        tick(6);
        chk("tmo_park_valid", {31'd0, VALID},   32'd0);
        chk("tmo_park_ack",   {31'd0, ACK_OUT}, 32'd0);
        // ERR clear pulse
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        chk("errclr", {31'd0, ERR}, 32'd0);
        REQ_IN = 1'b0;
        tick(4);

        // ERR_CLR coincident with timeout: set wins
        send(8'h42);
        wait_valid("tmo2", 8);
        tick(1);
        for (int i = 1; i < ACK_TIMEOUT; i++) tick(1);
        chk("tmo2_ack_last", {31'd0, ACK_OUT}, 32'd1);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        chk("tmo2_ack_drop", {31'd0, ACK_OUT}, 32'd0);
        chk("tmo2_err_win",  {31'd0, ERR},     32'd1);
        tick(1);
        chk("tmo2_err_keep", {31'd0, ERR},     32'd1);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;
        chk("tmo2_errclr", {31'd0, ERR}, 32'd0);
        REQ_IN = 1'b0;
        tick(4);

        // Isolation abort while VALID
        READY = 1'b0;
        send(8'h5A);
        wait_valid("iso", 8);
        ISO_IN = 1'b1;
        tick(SYNC_STAGES);
        chk("iso_valid_still", {31'd0, VALID}, 32'd1);
        tick(1);
        chk("iso_valid", {31'd0, VALID},    32'd0);
        chk("iso_ack",   {31'd0, ACK_OUT},  32'd0);
        chk("iso_err",   {31'd0, ERR},      32'd1);
        chk("iso_data",  {24'd0, DATA_OUT}, 32'h5A);
        REQ_IN = 1'b0;
        ISO_IN = 1'b0;
        READY  = 1'b1;
        tick(4);
        ERR_CLR = 1'b1;
        tick(1);
        ERR_CLR = 1'b0;

        // Back in IDLE: a fresh transfer must go through
        send(8'hC3);
        wait_valid("post_iso", 8);
        tick(1);
        chk("post_iso_ack", {31'd0, ACK_OUT}, 32'd1);

        // Asynchronous reset while ACK is high
        #2 RESET = 1'b1;
        #1;
        chk("arst_ack",   {31'd0, ACK_OUT}, 32'd0);
        chk("arst_valid", {31'd0, VALID},   32'd0);
        REQ_IN = 1'b0;
        @(negedge CLK);
        tick(1);
        RESET = 1'b0;
        tick(4);

        // Back-to-back transfers after reset
        send(8'h01);
        wait_valid("b2b0", 8);
        tick(1);
        chk("b2b0_ack", {31'd0, ACK_OUT}, 32'd1);
        REQ_IN = 1'b0;
        wait_ack_low("b2b0", 8);
        send(8'h02);
        wait_valid("b2b1", 10);
        tick(1);
        chk("b2b1_ack", {31'd0, ACK_OUT}, 32'd1);
        REQ_IN = 1'b0;
        wait_ack_low("b2b1", 8);

        chk("sb_drained", sb_q.size(), 32'd0);
        chk("final_err",  {31'd0, ERR}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_scs8hd_lpflow_lsbuf_hl_rx
